// File: rtl/rv32_test_pkg.sv
// rtl/rv32_test_pkg.sv - shared types and constants for the rv32 test result monitor
//
// Contents:
//    mon_state_t  - monitor FSM state encoding
//    REG_*        - architectural register indices watched on the write-back port
//    DONE_MAGIC   - value written to the done register that triggers a verdict
//    sat_inc32    - saturating 32-bit increment

package rv32_test_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } mon_state_t;

   // Test-harness register convention: x3 carries the current test number,
   // x26 is written with DONE_MAGIC when the program finishes, x27 holds
   // the result (DONE_MAGIC means pass).
   localparam logic [4:0]  REG_TESTNUM = 5'd3;
   localparam logic [4:0]  REG_DONE    = 5'd26;
   localparam logic [4:0]  REG_RESULT  = 5'd27;
   localparam logic [31:0] DONE_MAGIC  = 32'h0000_0001;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - snoops the register write-back port and latches a pass/fail verdict
//
// Build option: TEST_MONITOR_TIMEOUT_EN enables the run-time watchdog
// (TIMEOUT state); without it the watchdog is absent and timeout reads 0.
//
// Parameters:
//    SETTLE_CYCLES  - cycles between the done trigger and the verdict (0 acts as 1)
//    TIMEOUT_CYCLES - RUN cycles allowed before the watchdog fires
// Ports:
//    clk          in   clock, rising edge
//    rst          in   asynchronous active-low reset
//    wb_we        in   register write-back enable
//    wb_waddr     in   write-back destination register index
//    wb_wdata     in   write-back data
//    done         out  verdict available (sticky)
//    pass         out  test passed (sticky)
//    fail         out  test failed or timed out (sticky)
//    timeout      out  watchdog expired (sticky)
//    fail_testnum out  x3 value frozen at the verdict
//    cycle_count  out  cycles spent in RUN/SETTLE, saturating

module test_result_monitor
   import rv32_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 10,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [31:0] fail_testnum,
   output logic [31:0] cycle_count
);

   // A zero settle time still needs one cycle so the verdict edge is
   // distinct from the trigger edge.
   localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int          SCW        = $clog2(SETTLE_EFF + 1);
   localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_EFF);
   localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);

   mon_state_t     state_q, state_d;
   logic [SCW-1:0] settle_q, settle_d;
   logic [31:0]    x3_q, x3_d;
   logic [31:0]    x26_q, x26_d;
   logic [31:0]    x27_q, x27_d;
   logic [31:0]    cyc_q, cyc_d;
   logic [31:0]    testnum_q, testnum_d;
   logic           done_q, done_d;
   logic           pass_q, pass_d;
   logic           fail_q, fail_d;

   logic           active;
   logic           wr_valid;
   logic           trigger;

`ifdef TEST_MONITOR_TIMEOUT_EN
   localparam logic [32:0] TO_LIMIT = 33'(TIMEOUT_CYCLES);
   logic           timeout_q, timeout_d;
   logic           to_hit;
`else
   // x26 shadow and the timeout limit have no consumer in this build;
   // the shadow stays for hierarchy probing from the SoC.
   logic           unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CYCLES, x26_q};
`endif

   assign active   = (state_q == ST_RUN) || (state_q == ST_SETTLE);
   // x0 is hardwired to zero in the register file, so its writes are dropped.
   assign wr_valid = active && wb_we && (wb_waddr != 5'd0);
   assign trigger  = (state_q == ST_RUN) && wr_valid &&
                     (wb_waddr == REG_DONE) && (wb_wdata == DONE_MAGIC);

`ifdef TEST_MONITOR_TIMEOUT_EN
   // Fires on the edge where cycle_count becomes TIMEOUT_CYCLES, so the
   // frozen count equals the limit.
   assign to_hit = ({1'b0, cyc_q} + 33'd1) >= TO_LIMIT;
`endif

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      x3_d      = x3_q;
      x26_d     = x26_q;
      x27_d     = x27_q;
      cyc_d     = cyc_q;
      testnum_d = testnum_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
`ifdef TEST_MONITOR_TIMEOUT_EN
      timeout_d = timeout_q;
`endif

      // Shadow updates happen first so the verdict below sees writes
      // presented on the same edge.
      if (wr_valid) begin
         if (wb_waddr == REG_TESTNUM) x3_d  = wb_wdata;
         if (wb_waddr == REG_DONE)    x26_d = wb_wdata;
         if (wb_waddr == REG_RESULT)  x27_d = wb_wdata;
      end

      if (active) cyc_d = sat_inc32(cyc_q);

      case (state_q)
         ST_RUN: begin
            if (trigger) begin
               state_d  = ST_SETTLE;
               settle_d = SETTLE_LOAD;
            end
`ifdef TEST_MONITOR_TIMEOUT_EN
            else if (to_hit) begin
               state_d   = ST_TIMEOUT;
               done_d    = 1'b1;
               fail_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
               testnum_d = x3_d;
            end
`endif
         end
         ST_SETTLE: begin
            // Re-triggers are ignored here; only the down-counter matters.
            if (settle_q == SETTLE_ONE) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               pass_d    = (x27_d == DONE_MAGIC);
               fail_d    = (x27_d != DONE_MAGIC);
               testnum_d = x3_d;
            end else begin
               settle_d = settle_q - SETTLE_ONE;
            end
         end
         default: begin
            // DONE / TIMEOUT: terminal until reset, everything held.
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         settle_q  <= '0;
         x3_q      <= '0;
         x26_q     <= '0;
         x27_q     <= '0;
         cyc_q     <= '0;
         testnum_q <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
`ifdef TEST_MONITOR_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         x3_q      <= x3_d;
         x26_q     <= x26_d;
         x27_q     <= x27_d;
         cyc_q     <= cyc_d;
         testnum_q <= testnum_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
`ifdef TEST_MONITOR_TIMEOUT_EN
         timeout_q <= timeout_d;
`endif
      end
   end

   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign fail_testnum = testnum_q;
   assign cycle_count  = cyc_q;
`ifdef TEST_MONITOR_TIMEOUT_EN
   assign timeout      = timeout_q;
`else
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_test_result_monitor.sv
// tb/tb_test_result_monitor.sv - directed self-checking bench for test_result_monitor

module tb_test_result_monitor;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [31:0] fail_testnum;
   logic [31:0] cycle_count;

   int n_cmp = 0;
   int n_err = 0;

   test_result_monitor #(
      .SETTLE_CYCLES (10),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_we       (wb_we),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .fail_testnum(fail_testnum),
      .cycle_count (cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; the following rising edge samples them.
   task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      wb_we    = we;
      wb_waddr = addr;
      wb_wdata = data;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b0;
      wb_we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b0;
      wb_we    = 1'b0;
      wb_waddr = '0;
      wb_wdata = '0;
      idle(3);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_pass",    {31'd0, pass},    32'd0);
      chk("rst_fail",    {31'd0, fail},    32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_testnum", fail_testnum,     32'd0);
      chk("rst_cycles",  cycle_count,      32'd0);

      // A: x27=1, x26=1 -> pass exactly 10 cycles after the trigger edge.
      do_reset();
      drive(1'b1, 5'd27, 32'd1);
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(9);
      chk("A_done_early", {31'd0, done}, 32'd0);
      chk("A_pass_early", {31'd0, pass}, 32'd0);
      idle(1);
      chk("A_done",   {31'd0, done}, 32'd1);
      chk("A_pass",   {31'd0, pass}, 32'd1);
      chk("A_fail",   {31'd0, fail}, 32'd0);
      chk("A_cycles", cycle_count,   32'd13);
      idle(4);
      chk("A_cycles_frozen", cycle_count,   32'd13);
      chk("A_done_sticky",   {31'd0, done}, 32'd1);
      // asynchronous reset while in DONE clears without a clock edge
      #3 rst = 1'b0;
      #1;
      chk("A_rst_done",   {31'd0, done}, 32'd0);
      chk("A_rst_pass",   {31'd0, pass}, 32'd0);
      chk("A_rst_cycles", cycle_count,   32'd0);
      @(negedge clk);
      rst = 1'b1;

      // B: x3=5, x27=0, x26=1 -> fail with test number 5.
      do_reset();
      drive(1'b1, 5'd3, 32'd5);
      drive(1'b1, 5'd27, 32'd0);
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(10);
      chk("B_done",    {31'd0, done}, 32'd1);
      chk("B_fail",    {31'd0, fail}, 32'd1);
      chk("B_pass",    {31'd0, pass}, 32'd0);
      chk("B_testnum", fail_testnum,  32'd5);

      // C: x27=1 written 4 cycles into SETTLE still counts; x3 after done ignored.
      do_reset();
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      drive(1'b0, 5'd0, 32'd0);
      drive(1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd27, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(6);
      chk("C_done", {31'd0, done}, 32'd1);
      chk("C_pass", {31'd0, pass}, 32'd1);
      drive(1'b1, 5'd3, 32'd7);
      drive(1'b0, 5'd0, 32'd0);
      chk("C_testnum_held", fail_testnum,  32'd0);
      chk("C_pass_held",    {31'd0, pass}, 32'd1);

      // D: x27=1 presented on the very edge that ends SETTLE is forwarded.
      do_reset();
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(8);
      chk("D_done_early", {31'd0, done}, 32'd0);
      drive(1'b1, 5'd27, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      chk("D_done", {31'd0, done}, 32'd1);
      chk("D_pass", {31'd0, pass}, 32'd1);
      chk("D_fail", {31'd0, fail}, 32'd0);

      // E: x26=2 and x0=1 must not trigger; a later x26=1 does.
      do_reset();
      drive(1'b1, 5'd26, 32'd2);
      drive(1'b1, 5'd0, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(15);
      chk("E_no_trigger", {31'd0, done}, 32'd0);
      chk("E_cycles",     cycle_count,   32'd18);
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(10);
      chk("E_done", {31'd0, done}, 32'd1);
      chk("E_fail", {31'd0, fail}, 32'd1);
      chk("E_pass", {31'd0, pass}, 32'd0);

      // F: reset mid-SETTLE aborts; no residual x27 shadow; fresh pass works.
      do_reset();
      drive(1'b1, 5'd27, 32'd1);
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(4);
      #3 rst = 1'b0;
      #1;
      chk("F_abort_done",   {31'd0, done}, 32'd0);
      chk("F_abort_pass",   {31'd0, pass}, 32'd0);
      chk("F_abort_cycles", cycle_count,   32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(10);
      chk("F_no_residual_pass", {31'd0, pass}, 32'd0);
      chk("F_no_residual_fail", {31'd0, fail}, 32'd1);
      do_reset();
      drive(1'b1, 5'd27, 32'd1);
      drive(1'b1, 5'd26, 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      idle(10);
      chk("F_fresh_done", {31'd0, done}, 32'd1);
      chk("F_fresh_pass", {31'd0, pass}, 32'd1);

      // G: watchdog behaviour with TIMEOUT_CYCLES=50.
      do_reset();
`ifdef TEST_MONITOR_TIMEOUT_EN
      idle(49);
      chk("G_done_early", {31'd0, done}, 32'd0);
      chk("G_cycles_49",  cycle_count,   32'd49);
      idle(1);
      chk("G_done",    {31'd0, done},    32'd1);
      chk("G_fail",    {31'd0, fail},    32'd1);
      chk("G_pass",    {31'd0, pass},    32'd0);
      chk("G_timeout", {31'd0, timeout}, 32'd1);
      chk("G_cycles",  cycle_count,      32'd50);
      idle(3);
      chk("G_cycles_frozen", cycle_count, 32'd50);
`else
      idle(60);
      chk("G_no_done",    {31'd0, done},    32'd0);
      chk("G_no_timeout", {31'd0, timeout}, 32'd0);
      chk("G_cycles",     cycle_count,      32'd60);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
